ps2_kbd_event_rx: RTL and testbench
===================================

Name: ps2_kbd_event_rx

Overview:
- Parametrised PS/2 keyboard receiver; successor to the single-byte scan-code FIFO receiver.
- Synchronises and filters ps2_clk, deserialises 11-bit frames, and checks start, stop and odd parity.
- Decodes the E0/F0 prefix sequences into complete key events {ext, release, code}.
- Buffers events in a parametrised FIFO with a valid/ready pop handshake for the downstream display/ASCII logic, and reports frame errors, timeouts and overflow.

Parameters:
- DEPTH, 8: event FIFO depth; power of two, 2..64.
- FILT_LEN, 4: ps2_clk glitch filter; the synchronised level must be stable for FILT_LEN clk cycles before it is accepted.
- TIMEOUT_CYC, 50000: idle clk cycles mid-frame before the frame is aborted.
- CW, 8: width of err_cnt.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- ev_valid  out  1  FIFO head event available.
- ev_ready  in  1  consumer accepts the head event.
- ev_code  out  8  scan code of the head event.
- ev_ext  out  1  head event was E0-prefixed.
- ev_rel  out  1  head event is a release (F0-prefixed).
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- err_cnt  out  CW  saturating count of bad frames and timeouts.
- byte_stb  out  1  one-cycle pulse for each valid raw byte received.

Behaviour:
- Reset (rst=1 at a clk edge) clears everything, including any mid-frame state:
  - outputs: ev_valid=0, ev_code=0, ev_ext=0, ev_rel=0, level=0, overflow=0, err_cnt=0, byte_stb=0;
  - internal: bit counter, prefix flags, FIFO pointers, filter state; the filtered clock level resets to 1.
- Input path:
  - ps2_clk and ps2_data each pass through 2-flop synchronisers.
  - The clock filter then updates the filtered level only after FILT_LEN consecutive equal samples.
  - A sample event is a filtered 1->0 transition; ps2_data is sampled by the synchroniser on the same cycle.
- Frame FSM, states IDLE, SHIFT, CHECK:
  - IDLE: on a sample event with data=0 (start bit), go to SHIFT with bitcnt=1. A sample event with data=1 is ignored.
  - SHIFT: bits 1..8 are data (LSB first), bit 9 is parity, bit 10 is stop. After bit 10, go to CHECK.
  - CHECK (one cycle): valid if stop=1 and ^{data,parity}=1. Valid: byte_stb=1, pass the byte to the decoder. Invalid: err_cnt += 1 (saturating at 2^CW-1). Return to IDLE.
  - Timeout: in SHIFT, a 32-bit idle counter increments each clk with no sample event and clears on each sample event. At TIMEOUT_CYC it aborts to IDLE, err_cnt += 1, and the partial byte is discarded.
- Event decoder, applied to each valid byte:
  - 0xE0: set ext_f, no push.
  - 0xF0: set rel_f, no push.
  - Any other byte: push {ext_f, rel_f, byte}, then clear both flags.
  - 0x00 and 0xFF (keyboard error/overrun codes): not pushed; flags cleared; err_cnt += 1.
  - Push occurs in the cycle after CHECK, so latency is stop-bit sample event +2 clk to ev_valid=1 when the FIFO was empty.
- FIFO and handshake:
  - Pop when ev_valid & ev_ready. The head fields are valid whenever ev_valid=1 and hold stable until popped.
  - Full and push without pop: the event is dropped, overflow<=1 (sticky until rst), level unchanged.
  - Full and push with pop in the same cycle: both occur; level stays DEPTH; no overflow.
  - Empty: ev_valid=0, and ev_ready is ignored.
  - Pointers wrap modulo DEPTH; level is exact over 0..DEPTH.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - A held-key register {ext, code, held} is set by each pushed make event and cleared by the matching release.
  - A make event equal to the held key, while held=1, is suppressed: not pushed, and no error is counted.
  - A release of a different key leaves the register unchanged.
  - Reset clears held.
- Not defined: every make, including typematic repeats, is pushed.

Test Plan:
- Frame 0x1C (start 0, data LSB first, parity 0, stop 1), ev_ready=0 -> ev_valid=1, ev_code=0x1C, ev_ext=0, ev_rel=0, level=1, byte_stb pulsed once.
- Bytes E0,F0,75 -> a single event with ext=1, rel=1, code=0x75; the E0 and F0 bytes do not change level.
- Frame 0x1C with parity bit 1 -> no push, err_cnt=1. A frame stalled after 5 bits for TIMEOUT_CYC -> err_cnt=2; the next good frame 0x32 is received correctly.
- DEPTH=8, ev_ready=0, 9 make codes -> level=8, overflow=1, head=first code. Then hold ev_ready=1 with ev_valid asserted during a new push -> level stays 8 and overflow is not re-triggered.
- 2 ns ps2_clk glitches shorter than FILT_LEN cycles injected mid-frame -> no extra bits; byte received correctly.
- With PS2_TYPEMATIC_FILTER_EN defined: 1C,1C,1C,F0,1C,1C -> events make 1C, release 1C, make 1C (level=3). Without the macro: level=5.

Source files
------------

// File: rtl/ps2_kbd_event_rx.sv
// ============================================================================
// Module      : ps2_kbd_event_rx
// Description : PS/2 keyboard receiver: filtered clock, 11-bit frame check,
//               E0/F0 prefix decoding into {ext, rel, code} events, and an
//               event FIFO with a valid/ready pop handshake.
//               Optional macro PS2_TYPEMATIC_FILTER_EN suppresses typematic
//               repeats of the currently held key.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_kbd_event_rx #(
  parameter int DEPTH       = 8,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CW          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [7:0]               ev_code,
  output logic                     ev_ext,
  output logic                     ev_rel,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CW-1:0]            err_cnt,
  output logic                     byte_stb
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam int c_FW = $clog2(FILT_LEN) + 1;
  localparam logic [c_FW-1:0] c_FMAX    = c_FW'(FILT_LEN - 1);
  localparam logic [c_LW-1:0] c_FULL    = c_LW'(DEPTH);
  localparam logic [31:0]     c_TO_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_filt;
  logic [c_FW-1:0] r_fcnt;
  logic            w_fall;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_bitcnt;
  logic [9:0]      r_sh;
  logic [31:0]     r_idle;
  logic            w_frame_ok, w_frame_bad, w_timeout;

  logic [7:0]      w_byte;
  logic            w_is_key, w_dec_err, w_suppress;
  logic            r_ext_f, r_rel_f, r_push;
  logic [9:0]      r_push_ev;

  logic [9:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wp, r_rp;
  logic [c_LW-1:0] r_level;
  logic            r_ovf;
  logic [CW-1:0]   r_err;
  logic            w_pop, w_full, w_wr, w_err_inc;

  // Synchronisers and clock glitch filter; the filtered level moves only after
  // FILT_LEN consecutive samples that disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_filt   <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      if (r_clk_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == c_FMAX) begin
        r_filt <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_fall = r_filt & ~r_clk_s2 & (r_fcnt == c_FMAX);

  always_comb begin
    w_state_nxt = r_state;
    w_frame_ok  = 1'b0;
    w_frame_bad = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && !r_dat_s2) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_fall) begin
          if (r_bitcnt == 4'd10) w_state_nxt = S_CHECK;
        end else if (r_idle == c_TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_CHECK: begin
        w_frame_ok  = r_sh[9] & (^r_sh[8:0]);
        w_frame_bad = ~w_frame_ok;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_sh fills from the top so that after bit 10: [7:0]=data, [8]=parity, [9]=stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_sh     <= '0;
      r_idle   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_SHIFT && w_state_nxt == S_SHIFT) begin
        if (w_fall) begin
          r_sh     <= {r_dat_s2, r_sh[9:1]};
          r_bitcnt <= r_bitcnt + 4'd1;
          r_idle   <= '0;
        end else begin
          r_idle <= r_idle + 32'd1;
        end
      end else if (r_state == S_SHIFT && w_state_nxt == S_CHECK) begin
        r_sh <= {r_dat_s2, r_sh[9:1]};
      end else begin
        r_bitcnt <= 4'd1;
        r_idle   <= '0;
      end
    end
  end

  assign byte_stb  = w_frame_ok;
  assign w_byte    = r_sh[7:0];
  assign w_dec_err = w_frame_ok & ((w_byte == 8'h00) | (w_byte == 8'hFF));
  assign w_is_key  = w_frame_ok & (w_byte != 8'h00) & (w_byte != 8'hFF)
                   & (w_byte != 8'hE0) & (w_byte != 8'hF0);

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       r_held, r_held_ext;
  logic [7:0] r_held_code;
  logic       w_held_match;

  assign w_held_match = r_held & (r_held_ext == r_ext_f) & (r_held_code == w_byte);
  assign w_suppress   = ~r_rel_f & w_held_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held      <= 1'b0;
      r_held_ext  <= 1'b0;
      r_held_code <= '0;
    end else if (w_is_key) begin
      if (!r_rel_f && !w_suppress) begin
        r_held      <= 1'b1;
        r_held_ext  <= r_ext_f;
        r_held_code <= w_byte;
      end else if (r_rel_f && w_held_match) begin
        r_held <= 1'b0;
      end
    end
  end
`else
  assign w_suppress = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext_f   <= 1'b0;
      r_rel_f   <= 1'b0;
      r_push    <= 1'b0;
      r_push_ev <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_frame_ok) begin
        if (w_byte == 8'hE0) begin
          r_ext_f <= 1'b1;
        end else if (w_byte == 8'hF0) begin
          r_rel_f <= 1'b1;
        end else begin
          r_ext_f <= 1'b0;
          r_rel_f <= 1'b0;
          if (w_is_key && !w_suppress) begin
            r_push    <= 1'b1;
            r_push_ev <= {r_ext_f, r_rel_f, w_byte};
          end
        end
      end
    end
  end

  assign w_err_inc = w_frame_bad | w_timeout | w_dec_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= '0;
    end else if (w_err_inc && (r_err != '1)) begin
      r_err <= r_err + 1'b1;
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign ev_valid = (r_level != '0);
  assign w_pop    = ev_valid & ev_ready;
  assign w_full   = (r_level == c_FULL);
  assign w_wr     = r_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= r_push_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_wr && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_wr && w_pop) r_level <= r_level - 1'b1;
      if (r_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign {ev_ext, ev_rel, ev_code} = ev_valid ? r_mem[r_rp] : 10'd0;
  assign level    = r_level;
  assign overflow = r_ovf;
  assign err_cnt  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_kbd_event_rx.sv
// ============================================================================
// Module      : tb_ps2_kbd_event_rx
// Description : Self-checking bench for ps2_kbd_event_rx with an event
//               scoreboard and a table of prefix-sequence vectors.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_kbd_event_rx;

  localparam int DEPTH       = 8;
  localparam int FILT_LEN    = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int CW          = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_ext, ev_rel, overflow, byte_stb;
  logic [7:0] ev_code;
  logic [$clog2(DEPTH):0] level;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  ps2_kbd_event_rx #(
    .DEPTH(DEPTH), .FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_rel(ev_rel), .level(level), .overflow(overflow),
    .err_cnt(err_cnt), .byte_stb(byte_stb)
  );

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic [9:0] exp;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         stb_cnt = 0;
  logic [9:0] sb_q[$];
  vec_t       vt[6];

  always @(negedge clk) if (byte_stb) stb_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Device-driven frame: data changes while ps2_clk is high, sampled on fall.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (glitch) begin #40 ps2_clk = 1'b0; #2 ps2_clk = 1'b1; #58; end
      else #100;
      ps2_clk = 1'b0;
      if (glitch) begin #90 ps2_clk = 1'b1; #2 ps2_clk = 1'b0; #108; end
      else #200;
      ps2_clk = 1'b1;
      #100;
    end
    ps2_data = 1'b1;
    #300;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
  endtask

  task automatic pop_check(input string name);
    int t;
    logic [9:0] e;
    t = 0;
    @(negedge clk);
    while (!ev_valid && t < 1000) begin @(negedge clk); t++; end
    chk({name, "_valid"}, 32'(ev_valid), 32'd1);
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got event %0h", name, {ev_ext, ev_rel, ev_code});
    end else begin
      e = sb_q.pop_front();
      chk(name, 32'({ev_ext, ev_rel, ev_code}), 32'(e));
    end
    if (ev_valid) begin
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb_q.size() > 0) begin
      pop_check($sformatf("%s_%0d", name, k));
      k++;
    end
    repeat (2) @(negedge clk);
    chk({name, "_level0"}, 32'(level), 32'd0);
  endtask

  // Pops the head in exactly the cycle the next event is written.
  task automatic sim_pop();
    int t;
    logic [9:0] e;
    t = 0;
    while (!byte_stb && t < 2000) begin @(negedge clk); t++; end
    chk("simpop_stb", 32'(byte_stb), 32'd1);
    @(negedge clk);
    e = sb_q.pop_front();
    chk("simpop_head", 32'({ev_ext, ev_rel, ev_code}), 32'(e));
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    int s0, e0;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    logic [7:0] seq [3];

    vt[0] = '{8'hF0, 8'h1C, 8'h00, 2, {1'b0, 1'b1, 8'h1C}};
    vt[1] = '{8'hE0, 8'h6B, 8'h00, 2, {1'b1, 1'b0, 8'h6B}};
    vt[2] = '{8'hE0, 8'hF0, 8'h6B, 3, {1'b1, 1'b1, 8'h6B}};
    vt[3] = '{8'h5A, 8'h00, 8'h00, 1, {1'b0, 1'b0, 8'h5A}};
    vt[4] = '{8'hF0, 8'h5A, 8'h00, 2, {1'b0, 1'b1, 8'h5A}};
    vt[5] = '{8'hE0, 8'h4A, 8'h00, 2, {1'b1, 1'b0, 8'h4A}};

    repeat (4) @(negedge clk);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_err",   32'(err_cnt), 32'd0);
    chk("rst_stb",   32'(byte_stb), 32'd0);
    chk("rst_code",  32'({ev_ext, ev_rel, ev_code}), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single make code, consumer not ready
    s0 = stb_cnt;
    send_byte(8'h1C);
    sb_q.push_back({1'b0, 1'b0, 8'h1C});
    repeat (5) @(negedge clk);
    chk("t1_valid", 32'(ev_valid), 32'd1);
    chk("t1_code",  32'(ev_code), 32'h1C);
    chk("t1_ext",   32'(ev_ext), 32'd0);
    chk("t1_rel",   32'(ev_rel), 32'd0);
    chk("t1_level", 32'(level), 32'd1);
    chk("t1_stb",   32'(stb_cnt - s0), 32'd1);
    pop_check("t1_pop");

    // Prefix sequence E0 F0 75
    s0 = stb_cnt;
    send_byte(8'hE0);
    chk("e0_level", 32'(level), 32'd0);
    send_byte(8'hF0);
    chk("f0_level", 32'(level), 32'd0);
    send_byte(8'h75);
    sb_q.push_back({1'b1, 1'b1, 8'h75});
    chk("ef75_stb", 32'(stb_cnt - s0), 32'd3);
    pop_check("ef75_pop");

    for (int i = 0; i < 6; i++) begin
      seq[0] = vt[i].b0;
      seq[1] = vt[i].b1;
      seq[2] = vt[i].b2;
      for (int j = 0; j < vt[i].n; j++) begin
        send_byte(seq[j]);
        if (j < vt[i].n - 1) chk($sformatf("vec%0d_pre%0d_level", i, j), 32'(level), 32'd0);
      end
      sb_q.push_back(vt[i].exp);
      pop_check($sformatf("vec%0d", i));
    end

    // Errors: bad parity, mid-frame timeout, then a clean frame
    s0 = stb_cnt;
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    repeat (5) @(negedge clk);
    chk("par_err",   32'(err_cnt), 32'd1);
    chk("par_level", 32'(level), 32'd0);
    chk("par_stb",   32'(stb_cnt - s0), 32'd0);
    send_frame(8'hAA, 1'b0, 5, 1'b0);
    repeat (TIMEOUT_CYC + 50) @(negedge clk);
    chk("to_err", 32'(err_cnt), 32'd2);
    send_byte(8'h32);
    sb_q.push_back({1'b0, 1'b0, 8'h32});
    pop_check("after_to");
    send_byte(8'h00);
    repeat (5) @(negedge clk);
    chk("kbd00_err",   32'(err_cnt), 32'd3);
    chk("kbd00_level", 32'(level), 32'd0);
    send_byte(8'hE0);
    send_byte(8'hFF);
    send_byte(8'h1C);
    sb_q.push_back({1'b0, 1'b0, 8'h1C});
    chk("kbdff_err", 32'(err_cnt), 32'd4);
    pop_check("flags_cleared");

    // Fill, simultaneous push/pop at full, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'h15 + 8'(i));
      sb_q.push_back({1'b0, 1'b0, 8'h15 + 8'(i)});
    end
    chk("full_level", 32'(level), 32'd8);
    chk("full_ovf",   32'(overflow), 32'd0);
    chk("full_head",  32'(ev_code), 32'h15);
    sb_q.push_back({1'b0, 1'b0, 8'h40});
    fork
      send_byte(8'h40);
      sim_pop();
    join
    chk("simpop_level", 32'(level), 32'd8);
    chk("simpop_ovf",   32'(overflow), 32'd0);
    send_byte(8'h41);
    chk("ovf_set",   32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_head",  32'(ev_code), 32'h16);
    drain("drain_ovf");
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Short glitches on ps2_clk in both phases of every bit
    s0 = stb_cnt;
    send_frame(8'h5A, 1'b0, 11, 1'b1);
    sb_q.push_back({1'b0, 1'b0, 8'h5A});
    pop_check("glitch");
    chk("glitch_err", 32'(err_cnt), 32'd4);
    chk("glitch_stb", 32'(stb_cnt - s0), 32'd1);

    // Typematic repeats
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'h1C);
    repeat (5) @(negedge clk);
`ifdef PS2_TYPEMATIC_FILTER_EN
    sb_q.push_back({1'b0, 1'b0, 8'h1C});
    sb_q.push_back({1'b0, 1'b1, 8'h1C});
    sb_q.push_back({1'b0, 1'b0, 8'h1C});
    chk("typ_level", 32'(level), 32'd3);
`else
    sb_q.push_back({1'b0, 1'b0, 8'h1C});
    sb_q.push_back({1'b0, 1'b0, 8'h1C});
    sb_q.push_back({1'b0, 1'b0, 8'h1C});
    sb_q.push_back({1'b0, 1'b1, 8'h1C});
    sb_q.push_back({1'b0, 1'b0, 8'h1C});
    chk("typ_level", 32'(level), 32'd5);
`endif
    drain("drain_typ");
    chk("typ_err", 32'(err_cnt), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
